// File: rtl/frodo_mac_stream.sv
// Streaming multiply-accumulate: D[k] = C[k] +/- S[k]*B[k] mod 2^q, LANES 16-bit lanes per word.
// Optional FRODO_MAC_STREAM_STALL_EN adds a stall input that freezes the stream.
module frodo_mac_stream #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
`ifdef FRODO_MAC_STREAM_STALL_EN
    input  logic                    stall,
`endif
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   len,
    input  logic [ADDR_WIDTH-1:0]   b_base,
    input  logic [ADDR_WIDTH-1:0]   c_base,
    input  logic [ADDR_WIDTH-1:0]   s_base,
    input  logic [ADDR_WIDTH-1:0]   d_base,
    input  logic [1:0]              level,
    input  logic                    sub,
    output logic [ADDR_WIDTH-1:0]   b_addr,
    output logic [ADDR_WIDTH-1:0]   c_addr,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    input  logic [LANES*16-1:0]     b_rd_data,
    input  logic [LANES*16-1:0]     c_rd_data,
    input  logic [LANES*8-1:0]      s_rd_data,
    output logic [ADDR_WIDTH-1:0]   d_addr,
    output logic                    d_we,
    output logic [LANES*16-1:0]     d_wr_data,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned WW = LANES * 16;
    localparam int unsigned SW = LANES * 8;
    localparam logic [ADDR_WIDTH-1:0] AOne = 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   b_addr_q, c_addr_q, s_addr_q, d_ptr_q, rem_q;
    logic                    sub_q, q15_q;
    logic [RD_LAT-1:0]       iss_q;
    logic [ADDR_WIDTH-1:0]   da_q [RD_LAT];
    logic [1:0]              cnt_q;
    logic [WW-1:0]           buf_b_q [2];
    logic [WW-1:0]           buf_c_q [2];
    logic [SW-1:0]           buf_s_q [2];
    logic [ADDR_WIDTH-1:0]   buf_a_q [2];
    logic [ADDR_WIDTH-1:0]   d_addr_q;
    logic [WW-1:0]           d_data_q;
    logic                    d_we_q;

    logic                    stall_w, accept, issue, arr, consume, pop, push, push_idx;
    logic [WW-1:0]           head_b, head_c;
    logic [SW-1:0]           head_s;
    logic [ADDR_WIDTH-1:0]   head_a;

`ifdef FRODO_MAC_STREAM_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    function automatic logic [WW-1:0] mac_word(input logic [WW-1:0] b, input logic [WW-1:0] c,
                                               input logic [SW-1:0] s, input logic sb,
                                               input logic q15);
        logic [WW-1:0] res;
        logic [15:0]   sx, p, r;
        res = '0;
        for (int j = 0; j < int'(LANES); j++) begin
            sx = {{8{s[j*8+7]}}, s[j*8+:8]};
            p  = sx * b[j*16+:16];
            r  = sb ? (c[j*16+:16] - p) : (c[j*16+:16] + p);
            if (q15) r[15] = 1'b0;
            res[j*16+:16] = r;
        end
        return res;
    endfunction

    assign accept  = (state_q == StIdle) && start && (len != '0);
    assign issue   = (state_q == StRun) && !stall_w;
    assign arr     = iss_q[RD_LAT-1];
    // Read data keeps arriving while stalled; it parks in a small buffer and
    // is consumed in order once the stall releases.
    assign consume = !stall_w && ((cnt_q != 2'd0) || arr);
    assign pop     = consume && (cnt_q != 2'd0);
    assign push    = arr && (stall_w || (cnt_q != 2'd0));
    assign push_idx = pop ? (cnt_q == 2'd2) : (cnt_q == 2'd1);

    always_comb begin
        head_b = b_rd_data;
        head_c = c_rd_data;
        head_s = s_rd_data;
        head_a = da_q[RD_LAT-1];
        if (cnt_q != 2'd0) begin
            head_b = buf_b_q[0];
            head_c = buf_c_q[0];
            head_s = buf_s_q[0];
            head_a = buf_a_q[0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (len == '0) ? StDone : StRun;
            StRun:   if (issue && (rem_q == '0)) state_d = StDrain;
            StDrain: if (!stall_w && d_we_q && (cnt_q == 2'd0) && !(|iss_q)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            b_addr_q <= '0;
            c_addr_q <= '0;
            s_addr_q <= '0;
            d_ptr_q  <= '0;
            rem_q    <= '0;
            sub_q    <= 1'b0;
            q15_q    <= 1'b0;
            iss_q    <= '0;
            cnt_q    <= 2'd0;
            d_addr_q <= '0;
            d_data_q <= '0;
            d_we_q   <= 1'b0;
            for (int i = 0; i < int'(RD_LAT); i++) da_q[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_b_q[i] <= '0;
                buf_c_q[i] <= '0;
                buf_s_q[i] <= '0;
                buf_a_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                b_addr_q <= b_base;
                c_addr_q <= c_base;
                s_addr_q <= s_base;
                d_ptr_q  <= d_base;
                rem_q    <= len - AOne;
                sub_q    <= sub;
                q15_q    <= (level == 2'd0);
            end
            if (issue) begin
                da_q[0] <= d_ptr_q;
                d_ptr_q <= d_ptr_q + AOne;
                // The final index leaves its address on the bus.
                if (rem_q != '0) begin
                    b_addr_q <= b_addr_q + AOne;
                    c_addr_q <= c_addr_q + AOne;
                    s_addr_q <= s_addr_q + AOne;
                    rem_q    <= rem_q - AOne;
                end
            end
            iss_q[0] <= issue;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                iss_q[i] <= iss_q[i-1];
                da_q[i]  <= da_q[i-1];
            end

            if (pop) begin
                buf_b_q[0] <= buf_b_q[1];
                buf_c_q[0] <= buf_c_q[1];
                buf_s_q[0] <= buf_s_q[1];
                buf_a_q[0] <= buf_a_q[1];
            end
            if (push) begin
                buf_b_q[push_idx] <= b_rd_data;
                buf_c_q[push_idx] <= c_rd_data;
                buf_s_q[push_idx] <= s_rd_data;
                buf_a_q[push_idx] <= da_q[RD_LAT-1];
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};

            if (consume) begin
                d_we_q   <= 1'b1;
                d_addr_q <= head_a;
                d_data_q <= mac_word(head_b, head_c, head_s, sub_q, q15_q);
            end else if (!stall_w) begin
                d_we_q   <= 1'b0;
            end
        end
    end

    assign b_addr    = b_addr_q;
    assign c_addr    = c_addr_q;
    assign s_addr    = s_addr_q;
    assign d_addr    = d_addr_q;
    assign d_wr_data = d_data_q;
    assign d_we      = d_we_q && !stall_w;
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = (state_q == StDone);

endmodule

// File: doc/frodo_mac_stream.md
Name: frodo_mac_stream

Overview:
- Parametrised successor to the fixed 4-lane, 64-bit Macs datapath.
- Streams a row of LEN words through LANES parallel lanes, computing D[i] = C[i] ± S[i]·B[i] mod 2^q.
- Operands are read from the dual-port RAM banks and results are written back, one word per cycle.
- Sits between Control and the RAM banks; Control issues one command and waits for done.

Parameters:
LANES, 4, number of parallel 16-bit lanes; wide words are LANES*16 bits, short words LANES*8 bits
ADDR_WIDTH, 12, RAM address width; also the width of len
RD_LAT, 1, RAM read latency in cycles (1 or 2)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
start  input  1  command strobe, accepted only in IDLE
len  input  ADDR_WIDTH  number of words to process
b_base  input  ADDR_WIDTH  base address of B (wide)
c_base  input  ADDR_WIDTH  base address of C (wide)
s_base  input  ADDR_WIDTH  base address of S (short)
d_base  input  ADDR_WIDTH  base address of destination D
level  input  2  0 gives q=15; 1, 2 and 3 give q=16
sub  input  1  0: C+S·B, 1: C−S·B
b_addr  output  ADDR_WIDTH  B read address
c_addr  output  ADDR_WIDTH  C read address
s_addr  output  ADDR_WIDTH  S read address
b_rd_data  input  LANES*16  B read data
c_rd_data  input  LANES*16  C read data
s_rd_data  input  LANES*8  S read data; each lane is signed 8-bit
d_addr  output  ADDR_WIDTH  write address
d_we  output  1  write enable
d_wr_data  output  LANES*16  write data
busy  output  1  high while a command is in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: state=IDLE. All addresses, d_we, d_wr_data, busy and done are 0. Takes effect immediately at any point; an aborted command issues no further writes.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches len, all bases, level and sub.
  - len≠0 → RUN, with busy=1 from the next cycle.
  - len=0 → DONE directly; no writes occur.
- RUN:
  - Index k=0..len−1 is issued one per cycle.
  - Read addresses are base+k mod 2^ADDR_WIDTH; wrap-around is silent.
  - After issuing k=len−1 → DRAIN.
- Pipeline per lane j:
  - Read data arrives RD_LAT cycles after its address.
  - One further registered compute stage follows; the write is presented on that same registered output.
  - Issue-to-d_we latency is RD_LAT+1 cycles.
  - d_addr = d_base+k, with wrap-around.
- Arithmetic per lane:
  - p = sext16(s_j)·b_j, keeping the low 16 bits.
  - r = c_j+p, or c_j−p when sub=1, mod 2^16.
  - q=15: r[15] is forced to 0.
- DRAIN: waits until the last write has been issued → DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle → IDLE.
- start while busy, or during DONE, is ignored. Latched fields are unaffected.
- Throughput is 1 word/cycle; there are no bubbles. Total command time from the start cycle to done is len+RD_LAT+2 cycles.
- D may alias C: each read of index k precedes its write. Overlapping D with B or S at a different index is undefined.
- The read address outputs hold their last value when not RUN.

Optional Feature:
- Macro: FRODO_MAC_STREAM_STALL_EN.
- Defined:
  - Adds port stall (input, 1).
  - While stall=1 the whole pipeline freezes: read addresses hold, pipeline registers hold, d_we=0, and the index does not advance.
  - On release, output resumes exactly where it stopped, with no lost or duplicated writes.
  - done is delayed by the number of stalled cycles.
  - Reset overrides stall.
- Undefined: no stall port; the pipeline never freezes.

Test Plan:
- LANES=4, level=1, sub=0, len=1, B=0x0004_0003_0002_0001, S=0x02_FF_01_03, C=0x0000_0000_0010_0000 → D=0x0008_FFFD_0012_0003; d_we at cycle RD_LAT+2 after start; done at cycle 3+RD_LAT.
- level=0, sub=1, C=0, S=0x01 in each lane, B=0x0001 in each lane, len=1 → each lane 0x7FFF (bit 15 masked).
- len=0 → done pulses the cycle after start; d_we never asserted; busy stays 0.
- len=8, d_base=0xFFE → writes to 0xFFE, 0xFFF, 0x000…0x005 on 8 consecutive cycles; second start during busy ignored.
- rstn low at the 4th write of len=16 → d_we=0, busy=0 immediately; a new command after reset completes normally.
- FRODO_MAC_STREAM_STALL_EN, len=6, stall for 3 cycles mid-stream → 6 writes with correct data; done 3 cycles later than without stall.
